// File: rtl/hazard_forwarding_unit.sv
// -----------------------------------------------------------------------------
// hazard_forwarding_unit
//
// Execution-stage controller for a pipeline with stages
// IF / ID / EX / DM1 / DM2 / DM3 / WB.
//
// What it does:
//   - Keeps a shadow copy of the destination register of every in-flight
//     instruction, from EX down to WB.
//   - Decides, while an instruction is still in decode, where each of its two
//     ALU operands must come from once it reaches EX.
//   - Registers those decisions so they line up with that instruction in EX.
//   - Detects load-use hazards and stalls decode until the load data reaches
//     WB. A bubble is injected into EX for every stall cycle.
//   - Honours a branch-taken flush and a global data-cache freeze.
//
// Operand select encoding (both muxes):
//   0 = register file      1 = PC (mux 1) / immediate (mux 2)
//   2 = DM1                3 = DM2
//   4 = DM3                5 = WB
//   Codes 6 and 7 are never produced.
//
// Optional feature:
//   HAZARD_STATS_EN  When defined, STALL_COUNT counts the load-use stall
//                    cycles, wrapping at 2^32. When undefined, STALL_COUNT is
//                    tied to 0 and no counter flops exist.
//
// Parameters:
//   HIGH  active level of all control strobes (inputs and outputs)
//
// Ports:
//   CLK                    in   1   pipeline clock
//   RST                    in   1   asynchronous, active-high reset
//   CACHE_STALL            in   1   global freeze from data cache
//   FLUSH                  in   1   branch taken in EX; kill decode instr
//   RS1_ADDRESS            in   5   decode-stage rs1
//   RS2_ADDRESS            in   5   decode-stage rs2
//   RS1_READ               in   1   decode instr reads rs1
//   RS2_READ               in   1   decode instr reads rs2
//   OP1_IS_PC              in   1   operand 1 is PC (AUIPC/JAL)
//   OP2_IS_IMM             in   1   operand 2 is immediate
//   RD_ADDRESS             in   5   decode-stage rd
//   RD_WRITE_ENABLE        in   1   decode instr writes rd
//   IS_LOAD                in   1   decode instr is a load
//   ALU_IN1_MUX_SELECT     out  3   registered operand-1 select to EX
//   ALU_IN2_MUX_SELECT     out  3   registered operand-2 select to EX
//   STALL_DECODE           out  1   hold PC/IF/ID this cycle
//   CLEAR_EXECUTION_STAGE  out  1   insert bubble into EX at next edge
//   STALL_COUNT            out  32  load-use stall cycles (feature only)
// -----------------------------------------------------------------------------
module hazard_forwarding_unit #(
   parameter logic HIGH = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CACHE_STALL,
   input  logic        FLUSH,
   input  logic [4:0]  RS1_ADDRESS,
   input  logic [4:0]  RS2_ADDRESS,
   input  logic        RS1_READ,
   input  logic        RS2_READ,
   input  logic        OP1_IS_PC,
   input  logic        OP2_IS_IMM,
   input  logic [4:0]  RD_ADDRESS,
   input  logic        RD_WRITE_ENABLE,
   input  logic        IS_LOAD,
   output logic [2:0]  ALU_IN1_MUX_SELECT,
   output logic [2:0]  ALU_IN2_MUX_SELECT,
   output logic        STALL_DECODE,
   output logic        CLEAR_EXECUTION_STAGE,
   output logic [31:0] STALL_COUNT
);

   localparam logic [2:0] SEL_REGFILE = 3'd0;
   localparam logic [2:0] SEL_PC_IMM  = 3'd1;
   localparam logic [2:0] SEL_DM1     = 3'd2;
   localparam logic [2:0] SEL_DM2     = 3'd3;
   localparam logic [2:0] SEL_DM3     = 3'd4;
   localparam logic [2:0] SEL_WB      = 3'd5;

   // Result of looking one source register up in the shadow pipe.
   typedef struct packed {
      logic       hazard;   // youngest producer is a load whose data is not ready
      logic [2:0] sel;      // forwarding select, ignoring PC/IMM overrides
   } fwd_t;

   // Shadow pipe: _p0 = EX, _p1 = DM1, _p2 = DM2, _p3 = DM3, _p4 = WB.
   logic       vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
   logic [4:0] rd_p0, rd_p1, rd_p2, rd_p3, rd_p4;
   logic       ld_p0, ld_p1, ld_p2, ld_p3, ld_p4;

   logic [4:0]       vld_vec;
   logic [4:0][4:0]  rd_vec;
   logic [4:0]       ld_vec;

   // Strobes normalised to positive logic.
   logic cache_stall;
   logic flush;
   logic rs1_read;
   logic rs2_read;
   logic op1_is_pc;
   logic op2_is_imm;
   logic rd_write_enable;
   logic is_load;

   fwd_t       fwd1;
   fwd_t       fwd2;
   logic       load_use;
   logic       kill_ex;
   logic       dest_valid;
   logic [2:0] next_sel1;
   logic [2:0] next_sel2;
   logic [2:0] sel1_q;
   logic [2:0] sel2_q;

   // Select for a producer found in shadow slot `slot` while the consumer is
   // in decode: one edge later the producer has moved one slot further on,
   // and that slot's result bus is what the consumer must pick up in EX.
   // A producer already in WB has written the (write-through) register file.
   function automatic logic [2:0] slot_to_sel(input logic [2:0] slot);
      logic [2:0] sel;
      case (slot)
         3'd0:    sel = SEL_DM1;
         3'd1:    sel = SEL_DM2;
         3'd2:    sel = SEL_DM3;
         3'd3:    sel = SEL_WB;
         default: sel = SEL_REGFILE;
      endcase
      return sel;
   endfunction

   // Youngest matching slot wins. Load data only exists on the WB bus, so a
   // load found in EX, DM1 or DM2 cannot be forwarded yet.
   function automatic fwd_t lookup(
      input logic            rd_en,
      input logic [4:0]      rs,
      input logic [4:0]      vld,
      input logic [4:0][4:0] rd,
      input logic [4:0]      ld
   );
      fwd_t       res;
      logic [2:0] hit_slot;
      logic       hit;
      hit      = 1'b0;
      hit_slot = 3'd0;
      if (rd_en && (rs != 5'd0)) begin
         if (vld[0] && (rd[0] == rs)) begin
            hit      = 1'b1;
            hit_slot = 3'd0;
         end else if (vld[1] && (rd[1] == rs)) begin
            hit      = 1'b1;
            hit_slot = 3'd1;
         end else if (vld[2] && (rd[2] == rs)) begin
            hit      = 1'b1;
            hit_slot = 3'd2;
         end else if (vld[3] && (rd[3] == rs)) begin
            hit      = 1'b1;
            hit_slot = 3'd3;
         end else if (vld[4] && (rd[4] == rs)) begin
            hit      = 1'b1;
            hit_slot = 3'd4;
         end
      end
      res.sel    = hit ? slot_to_sel(hit_slot) : SEL_REGFILE;
      res.hazard = hit && ld[hit_slot] && (hit_slot <= 3'd2);
      return res;
   endfunction

   assign cache_stall     = (CACHE_STALL     == HIGH);
   assign flush           = (FLUSH           == HIGH);
   assign rs1_read        = (RS1_READ        == HIGH);
   assign rs2_read        = (RS2_READ        == HIGH);
   assign op1_is_pc       = (OP1_IS_PC       == HIGH);
   assign op2_is_imm      = (OP2_IS_IMM      == HIGH);
   assign rd_write_enable = (RD_WRITE_ENABLE == HIGH);
   assign is_load         = (IS_LOAD         == HIGH);

   assign vld_vec = {vld_p4, vld_p3, vld_p2, vld_p1, vld_p0};
   assign rd_vec  = {rd_p4,  rd_p3,  rd_p2,  rd_p1,  rd_p0};
   assign ld_vec  = {ld_p4,  ld_p3,  ld_p2,  ld_p1,  ld_p0};

   // ---- decode: hazard detection and next operand selects ----
   always_comb begin
      fwd1 = lookup(rs1_read, RS1_ADDRESS, vld_vec, rd_vec, ld_vec);
      fwd2 = lookup(rs2_read, RS2_ADDRESS, vld_vec, rd_vec, ld_vec);
      load_use = fwd1.hazard | fwd2.hazard;

      // PC / immediate operands never come from the register path.
      next_sel1 = op1_is_pc  ? SEL_PC_IMM : fwd1.sel;
      next_sel2 = op2_is_imm ? SEL_PC_IMM : fwd2.sel;

      // Either a flush or a load-use bubble turns the EX entry into a no-op.
      kill_ex = flush | load_use;

      // Writes to x0 are never tracked, so x0 can never be forwarded.
      dest_valid = rd_write_enable && (RD_ADDRESS != 5'd0);
   end

   assign STALL_DECODE          = (load_use | cache_stall) ? HIGH : ~HIGH;
   assign CLEAR_EXECUTION_STAGE = (!cache_stall && kill_ex) ? HIGH : ~HIGH;

   // ---- decode -> EX: shadow-pipe valids and registered selects ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         vld_p4 <= 1'b0;
         sel1_q <= SEL_REGFILE;
         sel2_q <= SEL_REGFILE;
      end else if (!cache_stall) begin
         vld_p0 <= kill_ex ? 1'b0 : dest_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         vld_p4 <= vld_p3;
         sel1_q <= kill_ex ? SEL_REGFILE : next_sel1;
         sel2_q <= kill_ex ? SEL_REGFILE : next_sel2;
      end
   end

   // ---- shadow-pipe payload: qualified by the valids, so no reset ----
   always_ff @(posedge CLK) begin
      if (!cache_stall) begin
         rd_p0 <= RD_ADDRESS;
         ld_p0 <= is_load;
         rd_p1 <= rd_p0;
         ld_p1 <= ld_p0;
         rd_p2 <= rd_p1;
         ld_p2 <= ld_p1;
         rd_p3 <= rd_p2;
         ld_p3 <= ld_p2;
         rd_p4 <= rd_p3;
         ld_p4 <= ld_p3;
      end
   end

   assign ALU_IN1_MUX_SELECT = sel1_q;
   assign ALU_IN2_MUX_SELECT = sel2_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt;

   // Counts only stall cycles that actually insert a load-use bubble: a
   // frozen cycle repeats nothing, and a flushed one discards the consumer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt <= 32'd0;
      end else if (load_use && !cache_stall && !flush) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign STALL_COUNT = stall_cnt;
`else
   assign STALL_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forwarding_unit
//
// Directed bench for hazard_forwarding_unit. A table of per-cycle decode
// records drives the DUT one record per clock. Each record carries:
//   - the expected combinational stall/clear outputs for that cycle, and
//   - the expected operand selects registered at the end of that cycle.
// Hand-written sequences cover reset behaviour, including reset in the middle
// of a load-use stall.
// -----------------------------------------------------------------------------
module tb_hazard_forwarding_unit;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic        clk = 1'b0;
   logic        rst;
   logic        cache_stall;
   logic        flush;
   logic [4:0]  rs1_address;
   logic [4:0]  rs2_address;
   logic        rs1_read;
   logic        rs2_read;
   logic        op1_is_pc;
   logic        op2_is_imm;
   logic [4:0]  rd_address;
   logic        rd_write_enable;
   logic        is_load;
   logic [2:0]  alu_in1_mux_select;
   logic [2:0]  alu_in2_mux_select;
   logic        stall_decode;
   logic        clear_execution_stage;
   logic [31:0] stall_count;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       r1;
      logic       r2;
      logic       pc;
      logic       imm;
      logic       we;
      logic       ld;
      logic       cs;
      logic       fl;
      logic       st;   // expected STALL_DECODE during the cycle
      logic       cl;   // expected CLEAR_EXECUTION_STAGE during the cycle
      logic [2:0] s1;   // expected ALU_IN1_MUX_SELECT after the edge
      logic [2:0] s2;   // expected ALU_IN2_MUX_SELECT after the edge
   } vec_t;

   vec_t vecs[$];

   hazard_forwarding_unit dut (
      .CLK                   (clk),
      .RST                   (rst),
      .CACHE_STALL           (cache_stall),
      .FLUSH                 (flush),
      .RS1_ADDRESS           (rs1_address),
      .RS2_ADDRESS           (rs2_address),
      .RS1_READ              (rs1_read),
      .RS2_READ              (rs2_read),
      .OP1_IS_PC             (op1_is_pc),
      .OP2_IS_IMM            (op2_is_imm),
      .RD_ADDRESS            (rd_address),
      .RD_WRITE_ENABLE       (rd_write_enable),
      .IS_LOAD               (is_load),
      .ALU_IN1_MUX_SELECT    (alu_in1_mux_select),
      .ALU_IN2_MUX_SELECT    (alu_in2_mux_select),
      .STALL_DECODE          (stall_decode),
      .CLEAR_EXECUTION_STAGE (clear_execution_stage),
      .STALL_COUNT           (stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Record builders
   // ---------------------------------------------------------------------------
   function automatic vec_t mk(
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic r1, r2, pc, imm, we, ld, cs, fl, st, cl,
      input logic [2:0] s1,
      input logic [2:0] s2
   );
      vec_t v;
      v.rd  = rd;
      v.rs1 = rs1;
      v.rs2 = rs2;
      v.r1  = r1;
      v.r2  = r2;
      v.pc  = pc;
      v.imm = imm;
      v.we  = we;
      v.ld  = ld;
      v.cs  = cs;
      v.fl  = fl;
      v.st  = st;
      v.cl  = cl;
      v.s1  = s1;
      v.s2  = s2;
      return v;
   endfunction

   // R-type ALU instruction: rd = rs1 op rs2.
   function automatic vec_t alu(
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic [2:0] s1,
      input logic [2:0] s2
   );
      return mk(rd, rs1, rs2, Y, Y, N, N, Y, N, N, N, N, N, s1, s2);
   endfunction

   // Plain bubble instruction: reads nothing and writes nothing.
   function automatic vec_t nop();
      return mk(5'd0, 5'd0, 5'd0, N, N, N, N, N, N, N, N, N, N, 3'd0, 3'd0);
   endfunction

   // Load: rd = mem[rs1]. The immediate is not modelled here.
   function automatic vec_t lw(input logic [4:0] rd, input logic [4:0] rs1);
      return mk(rd, rs1, 5'd0, Y, N, N, N, Y, Y, N, N, N, N, 3'd0, 3'd0);
   endfunction

   // ---------------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------------
   task automatic chk(
      input string       name,
      input int          idx,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rd_address      = v.rd;
      rs1_address     = v.rs1;
      rs2_address     = v.rs2;
      rs1_read        = v.r1;
      rs2_read        = v.r2;
      op1_is_pc       = v.pc;
      op2_is_imm      = v.imm;
      rd_write_enable = v.we;
      is_load         = v.ld;
      cache_stall     = v.cs;
      flush           = v.fl;
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [31:0] exp_cnt;
      vec_t        v;

      // -------------------------------------------------------------------
      // Table of per-cycle decode records
      // -------------------------------------------------------------------
      // Back-to-back ALU dependency: forward from DM1 on both operands.
      vecs.push_back(alu(5'd5, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(alu(5'd6, 5'd5, 5'd5, 3'd2, 3'd2));
      // Two NOPs between producer and consumer -> DM3.
      vecs.push_back(alu(5'd10, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(nop());
      vecs.push_back(nop());
      vecs.push_back(alu(5'd11, 5'd10, 5'd10, 3'd4, 3'd4));
      // Three NOPs -> WB.
      vecs.push_back(alu(5'd12, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(nop());
      vecs.push_back(nop());
      vecs.push_back(nop());
      vecs.push_back(alu(5'd13, 5'd12, 5'd12, 3'd5, 3'd5));
      // Four NOPs -> register file.
      vecs.push_back(alu(5'd14, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(nop());
      vecs.push_back(nop());
      vecs.push_back(nop());
      vecs.push_back(nop());
      vecs.push_back(alu(5'd15, 5'd14, 5'd14, 3'd0, 3'd0));
      // Two writers of x16: the younger one (in EX) wins.
      vecs.push_back(alu(5'd16, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(alu(5'd16, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(alu(5'd17, 5'd16, 5'd1, 3'd2, 3'd0));
      // PC / IMM override a live match.
      vecs.push_back(alu(5'd18, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(mk(5'd19, 5'd18, 5'd18, Y, Y, Y, Y, Y, N, N, N, N, N, 3'd1, 3'd1));
      // ADDI x0,x0,1 then ADD x9,x0,x0: x0 is never forwarded.
      vecs.push_back(mk(5'd0, 5'd0, 5'd0, Y, N, N, Y, Y, N, N, N, N, N, 3'd0, 3'd1));
      vecs.push_back(alu(5'd9, 5'd0, 5'd0, 3'd0, 3'd0));
      // LW x7 then ADD x8,x7,x1: three stall cycles, then WB forward.
      vecs.push_back(lw(5'd7, 5'd1));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(5'd8, 5'd7, 5'd1, Y, Y, N, N, Y, N, N, N, Y, Y, 3'd0, 3'd0));
      vecs.push_back(alu(5'd8, 5'd7, 5'd1, 3'd5, 3'd0));
      // Cache freeze holds non-zero selects.
      vecs.push_back(alu(5'd27, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(alu(5'd28, 5'd27, 5'd27, 3'd2, 3'd2));
      vecs.push_back(mk(5'd0, 5'd0, 5'd0, N, N, N, N, N, N, Y, N, Y, N, 3'd2, 3'd2));
      vecs.push_back(nop());
      // Cache freeze for 4 cycles in the middle of a load-use stall.
      vecs.push_back(lw(5'd25, 5'd1));
      vecs.push_back(mk(5'd26, 5'd25, 5'd1, Y, Y, N, N, Y, N, N, N, Y, Y, 3'd0, 3'd0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(5'd26, 5'd25, 5'd1, Y, Y, N, N, Y, N, Y, N, Y, N, 3'd0, 3'd0));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(5'd26, 5'd25, 5'd1, Y, Y, N, N, Y, N, N, N, Y, Y, 3'd0, 3'd0));
      vecs.push_back(alu(5'd26, 5'd25, 5'd1, 3'd5, 3'd0));
      // FLUSH while a load-use is pending in decode.
      vecs.push_back(lw(5'd20, 5'd1));
      vecs.push_back(mk(5'd21, 5'd20, 5'd20, Y, Y, N, N, Y, N, N, Y, Y, Y, 3'd0, 3'd0));
      // A flushed producer never forwards; the older x22 still does.
      vecs.push_back(alu(5'd22, 5'd1, 5'd2, 3'd0, 3'd0));
      vecs.push_back(mk(5'd23, 5'd22, 5'd1, Y, Y, N, N, Y, N, N, Y, N, Y, 3'd0, 3'd0));
      vecs.push_back(alu(5'd24, 5'd23, 5'd22, 3'd0, 3'd3));
      // Load in WB needs no forward; ALU result in EX does.
      vecs.push_back(alu(5'd31, 5'd20, 5'd24, 3'd0, 3'd2));
      // CACHE_STALL beats FLUSH.
      vecs.push_back(mk(5'd0, 5'd0, 5'd0, N, N, N, N, N, N, Y, Y, Y, N, 3'd0, 3'd2));
      vecs.push_back(nop());

      // -------------------------------------------------------------------
      // Reset state
      // -------------------------------------------------------------------
      rst = 1'b1;
      drive(nop());
      #7;
      chk("reset_sel1",  0, 32'(alu_in1_mux_select),    32'd0);
      chk("reset_sel2",  0, 32'(alu_in2_mux_select),    32'd0);
      chk("reset_stall", 0, 32'(stall_decode),          32'd0);
      chk("reset_clear", 0, 32'(clear_execution_stage), 32'd0);
      chk("reset_count", 0, stall_count,                32'd0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // -------------------------------------------------------------------
      // Table-driven vectors
      // -------------------------------------------------------------------
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v);
         @(negedge clk);
         chk("stall", i, 32'(stall_decode),          32'(v.st));
         chk("clear", i, 32'(clear_execution_stage), 32'(v.cl));
         @(posedge clk);
         #1;
         chk("sel1", i, 32'(alu_in1_mux_select), 32'(v.s1));
         chk("sel2", i, 32'(alu_in2_mux_select), 32'(v.s2));
      end

`ifdef HAZARD_STATS_EN
      exp_cnt = 32'd6;
`else
      exp_cnt = 32'd0;
`endif
      chk("stall_count_after_table", 0, stall_count, exp_cnt);

      // -------------------------------------------------------------------
      // Reset in the middle of a load-use stall
      // -------------------------------------------------------------------
      drive(alu(5'd3, 5'd1, 5'd2, 3'd0, 3'd0));
      @(posedge clk);
      #1;
      drive(lw(5'd29, 5'd3));
      @(posedge clk);
      #1;
      chk("midrst_pre_sel1", 0, 32'(alu_in1_mux_select), 32'd2);
      drive(alu(5'd30, 5'd29, 5'd1, 3'd0, 3'd0));
      #2;
      chk("midrst_pre_stall", 0, 32'(stall_decode), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_stall", 0, 32'(stall_decode),          32'd0);
      chk("midrst_clear", 0, 32'(clear_execution_stage), 32'd0);
      chk("midrst_sel1",  0, 32'(alu_in1_mux_select),    32'd0);
      chk("midrst_sel2",  0, 32'(alu_in2_mux_select),    32'd0);
      chk("midrst_count", 0, stall_count,                32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst_stall", 0, 32'(stall_decode), 32'd0);
      @(posedge clk);
      #1;
      chk("postrst_sel1", 0, 32'(alu_in1_mux_select), 32'd0);
      chk("postrst_sel2", 0, 32'(alu_in2_mux_select), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
